ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
- Execute-stage datapath that consumes the 4-bit Operation code produced by the ALU controller and the two operand values.
- Computes the ALU result and the branch-equal flag, and registers them into the EX/MEM boundary.
- Uses a valid/ready handshake with a 2-entry skid buffer, so MEM-side backpressure never creates a combinational path back to decode.
- Supports a pipeline flush for branch mispredicts.

Parameters:
- DATA_W, 32, operand and result width.
- REG_AW, 5, destination register address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- InValid  input  1  upstream holds a valid operation this cycle.
- InReady  output  1  stage can accept an operation this cycle.
- Operation  input  4  ALU operation select from the ALU controller.
- SrcA  input  DATA_W  operand A.
- SrcB  input  DATA_W  operand B (register or immediate, already muxed).
- RdAddrIn  input  REG_AW  destination register.
- RegWriteIn  input  1  writeback enable.
- Flush  input  1  discard all held and incoming operations.
- OutValid  output  1  EX/MEM entry valid.
- OutReady  input  1  downstream accepts the entry this cycle.
- ALUResult  output  DATA_W  registered result.
- Zero  output  1  registered: ALUResult == 0.
- RdAddrOut  output  REG_AW  registered destination.
- RegWriteOut  output  1  registered writeback enable.

Behaviour:
- Reset is asynchronous and active-low.
  - reset_n low clears OutValid, ALUResult, Zero, RdAddrOut, RegWriteOut and both skid entries to 0 immediately, independent of clk.
  - InReady is 1 while reset is asserted and after release.
- Operation decode. Any other code yields result 0 with no error.
  - 0000 AND
  - 0001 OR
  - 0010 XOR
  - 0100 ADD, modulo 2^DATA_W, carry discarded
  - 0101 SUB, A-B modulo 2^DATA_W
  - 0110 SLL by SrcB[4:0]
  - 0111 SRL by SrcB[4:0]
  - 1001 SRA by SrcB[4:0]
  - 1000 EQ: result = 1 if SrcA==SrcB, else 0
- Zero is computed from the selected result before registering. Consequences:
  - EQ with equal operands gives Zero=0.
  - SUB with equal operands gives Zero=1.
- Accept condition: InValid && InReady.
  - Latency is 1 cycle: an operation accepted at edge N appears on the outputs after edge N if the output register is free or is draining that cycle.
- Storage: the output register (OUT) plus one skid entry (SKID).
  - InReady = !SkidValid, taken from a register only, with no combinational dependence on OutReady.
- Edge update order, with drain = OutValid && OutReady:
  - If drain and SkidValid: SKID moves to OUT. A new accept in the same cycle goes to SKID.
  - If drain and !SkidValid: an accept goes to OUT, else OutValid clears.
  - If !drain and OutValid: an accept goes to SKID, and InReady drops next cycle.
  - If !OutValid: an accept goes to OUT.
- While OutValid && !OutReady, OUT contents must hold stable.
- Ordering is strictly FIFO; no operation is ever dropped or duplicated except by Flush.
- Flush has priority over everything at the edge:
  - OutValid and SkidValid are cleared.
  - Any operation accepted in the flush cycle is discarded.
  - Data fields need not be cleared.
  - InReady is 1 on the next cycle.
- Flush and drain in the same cycle: the downstream sees the current OUT as transferred (handshake complete); nothing else survives.
- RegWriteOut is meaningful only when OutValid=1; the downstream must qualify it.

Test Plan:
- Reset mid-stream: OUT and SKID both full; pulse reset_n low between edges -> outputs zero and InReady=1 immediately, without waiting for clk.
- Single op, OutReady=1: ADD of 0xFFFFFFFF and 0x00000002 -> next cycle OutValid=1, ALUResult=0x00000001, Zero=0. Then SUB of 5 and 5 -> ALUResult=0, Zero=1.
- Decode sweep:
  - EQ with 7, 7 -> result 1.
  - SRA with 0x80000000 and 4 -> 0xF8000000.
  - SLL with 1 and 31 -> 0x80000000.
  - Undefined code 1111 -> result 0, Zero=1.
- Backpressure: OutReady=0, issue ops A, B, C back-to-back.
  - A is held in OUT and B in SKID; InReady=0 from the cycle after B is accepted, so C is not accepted.
  - Raise OutReady -> outputs emerge as A, B, C in order, with no gaps once the stream flows.
- Flush: OUT and SKID full, with InValid=1 and an op presented while Flush=1 -> next cycle OutValid=0, InReady=1, and none of the three ops ever appears on the outputs.
- Randomised valid/ready toggling over 1000 ops -> scoreboard confirms in-order, lossless delivery and that OUT is stable whenever OutValid=1 and OutReady=0.

Source files
------------

// File: rtl/ex_alu_stage.sv
// ============================================================================
// ex_alu_stage : execute-stage ALU with EX/MEM output register and skid entry
// Revision 1.0
// ============================================================================
`default_nettype none

module ex_alu_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [REG_AW-1:0] RdAddrIn,
  input  logic              RegWriteIn,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero,
  output logic [REG_AW-1:0] RdAddrOut,
  output logic              RegWriteOut
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;

  // Entry layout: {zero, regwrite, rd, result}
  localparam int ENTRY_W = DATA_W + REG_AW + 2;

  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;
  logic [ENTRY_W-1:0] new_entry;
  logic               accept;
  logic               drain;

  logic               out_valid_d,  out_valid_q;
  logic [ENTRY_W-1:0] out_entry_d,  out_entry_q;
  logic               skid_valid_d, skid_valid_q;
  logic [ENTRY_W-1:0] skid_entry_d, skid_entry_q;

  always_comb begin
    alu_result = '0;
    case (Operation)
      OP_AND:  alu_result = SrcA & SrcB;
      OP_OR:   alu_result = SrcA | SrcB;
      OP_XOR:  alu_result = SrcA ^ SrcB;
      OP_ADD:  alu_result = SrcA + SrcB;
      OP_SUB:  alu_result = SrcA - SrcB;
      OP_SLL:  alu_result = SrcA << SrcB[4:0];
      OP_SRL:  alu_result = SrcA >> SrcB[4:0];
      OP_SRA:  alu_result = $unsigned($signed(SrcA) >>> SrcB[4:0]);
      OP_EQ:   alu_result = {{(DATA_W-1){1'b0}}, (SrcA == SrcB)};
      default: alu_result = '0;
    endcase
  end

  // Zero reflects the selected result, so EQ-true reads as non-zero.
  assign alu_zero  = (alu_result == '0);
  assign new_entry = {alu_zero, RegWriteIn, RdAddrIn, alu_result};

  // Ready comes straight from a flop: no combinational path from OutReady.
  assign InReady = !skid_valid_q;
  assign accept  = InValid && InReady;
  assign drain   = out_valid_q && OutReady;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_entry_d  = out_entry_q;
    skid_valid_d = skid_valid_q;
    skid_entry_d = skid_entry_q;
    if (Flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_entry_d  = skid_entry_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_entry_d = new_entry;
        end
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_entry_d = new_entry;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (out_valid_q) begin
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_entry_d = new_entry;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_entry_d = new_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_entry_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_entry_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_entry_q  <= out_entry_d;
      skid_valid_q <= skid_valid_d;
      skid_entry_q <= skid_entry_d;
    end
  end

  assign OutValid    = out_valid_q;
  assign ALUResult   = out_entry_q[DATA_W-1:0];
  assign RdAddrOut   = out_entry_q[DATA_W +: REG_AW];
  assign RegWriteOut = out_entry_q[DATA_W+REG_AW];
  assign Zero        = out_entry_q[DATA_W+REG_AW+1];

endmodule

`default_nettype wire

// File: tb/tb_ex_alu_stage.sv
// Directed and randomised bench for ex_alu_stage.
`default_nettype none

module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        InValid, InReady;
  logic [3:0]  Operation;
  logic [31:0] SrcA, SrcB;
  logic [4:0]  RdAddrIn;
  logic        RegWriteIn;
  logic        Flush;
  logic        OutValid, OutReady;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [4:0]  RdAddrOut;
  logic        RegWriteOut;

  int vectors    = 0;
  int miscompares = 0;

  ex_alu_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .RdAddrIn(RdAddrIn),
    .RegWriteIn(RegWriteIn), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
    .ALUResult(ALUResult), .Zero(Zero), .RdAddrOut(RdAddrOut), .RegWriteOut(RegWriteOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {OutValid, Zero, ALUResult}
  task automatic check_out(input string tag, input logic v, input logic z, input logic [31:0] r);
    check(tag, {31'd0, OutValid, Zero, ALUResult}, {31'd0, v, z, r});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic we);
    InValid = v; Operation = op; SrcA = a; SrcB = b; RdAddrIn = rd; RegWriteIn = we;
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a ^ b;
      4'b0100: return a + b;
      4'b0101: return a - b;
      4'b0110: return a << b[4:0];
      4'b0111: return a >> b[4:0];
      4'b1001: return $unsigned($signed(a) >>> b[4:0]);
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  logic [38:0] sb[$];
  logic [38:0] e;
  logic [38:0] held;
  logic [31:0] er;
  logic        hold;
  int          sent;
  int          cycles;

  initial begin
    reset_n = 1'b0; Flush = 1'b0; OutReady = 1'b1;
    put(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    #1;
    check("reset_out", {31'd0, OutValid, Zero, ALUResult}, 64'd0);
    check("reset_rd_we", {58'd0, RdAddrOut, RegWriteOut}, 64'd0);
    check("reset_inready", {63'd0, InReady}, 64'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single ops with downstream always ready
    put(1'b1, 4'b0100, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 1'b1);
    tick();
    check_out("add_wrap", 1'b1, 1'b0, 32'h0000_0001);
    check("add_rd_we", {58'd0, RdAddrOut, RegWriteOut}, {58'd0, 5'd3, 1'b1});
    put(1'b1, 4'b0101, 32'd5, 32'd5, 5'd4, 1'b0);
    tick(); check_out("sub_eq", 1'b1, 1'b1, 32'd0);
    put(1'b1, 4'b1000, 32'd7, 32'd7, 5'd5, 1'b1);
    tick(); check_out("eq_true", 1'b1, 1'b0, 32'd1);
    put(1'b1, 4'b1000, 32'd7, 32'd8, 5'd5, 1'b1);
    tick(); check_out("eq_false", 1'b1, 1'b1, 32'd0);
    put(1'b1, 4'b1001, 32'h8000_0000, 32'd4, 5'd6, 1'b1);
    tick(); check_out("sra", 1'b1, 1'b0, 32'hF800_0000);
    put(1'b1, 4'b0110, 32'd1, 32'd31, 5'd7, 1'b1);
    tick(); check_out("sll31", 1'b1, 1'b0, 32'h8000_0000);
    put(1'b1, 4'b0111, 32'h8000_0000, 32'h0000_0024, 5'd8, 1'b1);
    tick(); check_out("srl_shamt5b", 1'b1, 1'b0, 32'h0800_0000);
    put(1'b1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd9, 1'b1);
    tick(); check_out("and", 1'b1, 1'b0, 32'h0000_F000);
    put(1'b1, 4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 5'd9, 1'b1);
    tick(); check_out("or", 1'b1, 1'b0, 32'h0000_FFF0);
    put(1'b1, 4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 5'd9, 1'b1);
    tick(); check_out("xor", 1'b1, 1'b0, 32'h0000_0FF0);
    put(1'b1, 4'b1111, 32'h1234_5678, 32'h1, 5'd9, 1'b1);
    tick(); check_out("undef_1111", 1'b1, 1'b1, 32'd0);
    put(1'b1, 4'b0011, 32'h1234_5678, 32'h1, 5'd9, 1'b1);
    tick(); check_out("undef_0011", 1'b1, 1'b1, 32'd0);
    InValid = 1'b0;
    tick(); check("idle_valid", {63'd0, OutValid}, 64'd0);

    // Backpressure: A, B, C with OutReady low
    OutReady = 1'b0;
    put(1'b1, 4'b0100, 32'd1, 32'd0, 5'd1, 1'b1);
    tick(); check_out("bp_A", 1'b1, 1'b0, 32'd1);
    check("bp_ready_A", {63'd0, InReady}, 64'd1);
    put(1'b1, 4'b0100, 32'd2, 32'd0, 5'd2, 1'b1);
    tick(); check_out("bp_hold_A1", 1'b1, 1'b0, 32'd1);
    check("bp_ready_B", {63'd0, InReady}, 64'd0);
    put(1'b1, 4'b0100, 32'd3, 32'd0, 5'd3, 1'b1);
    tick(); check_out("bp_hold_A2", 1'b1, 1'b0, 32'd1);
    check("bp_ready_C", {63'd0, InReady}, 64'd0);
    OutReady = 1'b1;
    tick(); check_out("bp_B", 1'b1, 1'b0, 32'd2);
    check("bp_ready_after", {63'd0, InReady}, 64'd1);
    tick(); InValid = 1'b0;
    check_out("bp_C", 1'b1, 1'b0, 32'd3);
    tick(); check("bp_empty", {63'd0, OutValid}, 64'd0);

    // Flush with OUT and SKID full and a third op presented
    OutReady = 1'b0;
    put(1'b1, 4'b0100, 32'd10, 32'd0, 5'd1, 1'b1);
    tick();
    put(1'b1, 4'b0100, 32'd20, 32'd0, 5'd2, 1'b1);
    tick();
    put(1'b1, 4'b0100, 32'd30, 32'd0, 5'd3, 1'b1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    check("flush_valid", {63'd0, OutValid}, 64'd0);
    check("flush_ready", {63'd0, InReady}, 64'd1);
    tick(); check("flush_quiet1", {63'd0, OutValid}, 64'd0);
    tick(); check("flush_quiet2", {63'd0, OutValid}, 64'd0);

    // Flush coinciding with drain of a single held entry
    put(1'b1, 4'b0100, 32'd40, 32'd0, 5'd4, 1'b1);
    tick(); check_out("fd_W", 1'b1, 1'b0, 32'd40);
    put(1'b1, 4'b0100, 32'd50, 32'd0, 5'd5, 1'b1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0; InValid = 1'b0;
    check("fd_valid", {63'd0, OutValid}, 64'd0);

    // Asynchronous reset mid-stream with both entries full
    OutReady = 1'b0;
    put(1'b1, 4'b0100, 32'h11, 32'h22, 5'd7, 1'b1);
    tick();
    put(1'b1, 4'b0100, 32'h33, 32'h44, 5'd8, 1'b1);
    tick();
    InValid = 1'b0;
    check("full_before_rst", {63'd0, InReady}, 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out", {31'd0, OutValid, Zero, ALUResult}, 64'd0);
    check("arst_rd_we", {58'd0, RdAddrOut, RegWriteOut}, 64'd0);
    check("arst_ready", {63'd0, InReady}, 64'd1);
    #1 reset_n = 1'b1;
    tick();

    // Randomised valid/ready traffic against a FIFO scoreboard
    sent = 0; cycles = 0; hold = 1'b0;
    while ((sent < 1000 || sb.size() > 0) && cycles < 20000) begin
      if (hold)
        check("hold_stable", {25'd0, OutValid, Zero, RdAddrOut, RegWriteOut, ALUResult},
              {25'd0, 1'b1, held});
      put((sent < 1000) && ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
          $urandom, 32'd0, 5'(sent), 1'($urandom_range(0, 1)));
      SrcB = ($urandom_range(0, 3) == 0) ? SrcA : $urandom;
      OutReady = (sent >= 1000) ? 1'b1 : ($urandom_range(0, 9) < 6);
      if (OutValid && OutReady) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("stream", {25'd0, Zero, RdAddrOut, RegWriteOut, ALUResult}, {25'd0, e});
        end
      end
      hold = OutValid && !OutReady;
      held = {Zero, RdAddrOut, RegWriteOut, ALUResult};
      if (InValid && InReady) begin
        er = ref_alu(Operation, SrcA, SrcB);
        sb.push_back({(er == 32'd0), RdAddrIn, RegWriteIn, er});
        sent++;
      end
      tick();
      cycles++;
    end
    InValid = 1'b0;
    check("rand_timeout", {63'd0, (cycles >= 20000)}, 64'd0);
    check("rand_drained", 64'(sb.size()), 64'd0);
    check("rand_final_valid", {63'd0, OutValid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
